flex_counter_ud: RTL and testbench
==================================

Name: flex_counter_ud

Overview:
- Parametrised up/down flex counter with synchronous load, wrap or saturate mode, an optional enable prescaler, and registered terminal and wrap status.
- Replaces the up-only flex counter in the PCIe/Avalon-MM master datapath.
- Used for burst-length tracking, timeout timers and down-counting transfer budgets.
- Single clock domain.

Parameters:
- NUM_CNT_BITS, 8, counter width; minimum 2.
- PRESCALE_BITS, 4, prescaler width; used only with FLEX_CNT_PRESCALE_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous reset, active low.
- clear  in  1  synchronous clear; highest priority.
- load  in  1  synchronous load of load_val.
- load_val  in  NUM_CNT_BITS  value for load.
- count_enable  in  1  step request.
- up_down  in  1  1 = count up, 0 = count down; sampled per step.
- sat_mode  in  1  1 = saturate, 0 = wrap.
- rollover_val  in  NUM_CNT_BITS  upper bound or terminal value.
- prescale_val  in  PRESCALE_BITS  step every prescale_val+1 enabled cycles.
- count_out  out  NUM_CNT_BITS  registered count.
- terminal_flag  out  1  registered; high iff count_out == rollover_val.
- wrap_pulse  out  1  registered single-cycle pulse for a wrap or saturation hit.

Behaviour:
- Reset (n_rst low, asynchronous): count_out=0, terminal_flag=0, wrap_pulse=0, prescaler=0.
- Priority per cycle: clear > load > step.
- clear: count=0 and prescaler=0 next cycle; wrap_pulse=0.
- load: count=load_val and prescaler=0; no step that cycle; wrap_pulse=0.
- Step: occurs when count_enable=1 and the prescaler tick is true. Without the prescaler, tick = count_enable.
- Up, wrap mode:
  - count >= rollover_val -> next count = 1, wrap_pulse=1.
  - Otherwise next count = count+1.
- Up, saturate mode:
  - count >= rollover_val -> next count = rollover_val, wrap_pulse=1.
  - Otherwise next count = count+1.
- Down, wrap mode:
  - count <= 1 -> next count = rollover_val, wrap_pulse=1.
  - Otherwise next count = count-1.
- Down, saturate mode:
  - count == 0 -> next count holds at 0, wrap_pulse=1.
  - Otherwise next count = count-1.
- rollover_val == 0:
  - Up steps force count to 0; wrap_pulse=1 on each step.
  - Down steps follow the normal down rules with rollover_val=0.
- No step (count_enable=0 or no tick): count holds, wrap_pulse=0.
- terminal_flag = (next_count == rollover_val), registered with count.
  - Latency 1 cycle, aligned with count_out.
  - Level signal; it does not drop because count_enable deasserts.
- wrap_pulse: high for exactly one cycle after the triggering step, aligned with the updated count_out.
- Arithmetic: unsigned, NUM_CNT_BITS wide; the +1/-1 never escapes the range rules above.
- up_down change mid-count: takes effect on the next step; no flush.
- rollover_val reduced below count: the next up step wraps (or saturates) immediately.
- Reset mid-operation: all state returns to reset values immediately; no partial step.

Optional Feature:
- Macro: FLEX_CNT_PRESCALE_EN.
- Defined:
  - Internal PRESCALE_BITS counter advances on each count_enable cycle.
  - Tick is true when the prescaler equals prescale_val; the prescaler then returns to 0.
  - prescale_val=0 gives a tick on every enabled cycle.
  - The prescaler is zeroed by clear, load and reset.
  - prescale_val changes apply from the next compare.
- Undefined:
  - Prescaler logic is not generated; tick = count_enable.
  - prescale_val remains a port and is ignored.

Decomposition:
- Shared package flex_counter_pkg:
  - typedef enum logic {DIR_DOWN=0, DIR_UP=1} cnt_dir_e
  - typedef enum logic {MODE_WRAP=0, MODE_SAT=1} cnt_mode_e
  - localparam default widths
- Sub-module flex_prescaler (PRESCALE_BITS; clk, n_rst, clear, enable, prescale_val -> tick).
  - Instantiated only under FLEX_CNT_PRESCALE_EN.

Test Plan:
- Up/wrap, rollover_val=5, enable held: count 0,1,2,3,4,5,1,2...; terminal_flag high with count=5; wrap_pulse in the cycle count shows 1.
- Up/sat, rollover_val=3: count 1,2,3,3,3; wrap_pulse high on each held step; terminal_flag stays 1.
- Down/wrap, load 2 then enable: count 2,1,5,4 with rollover_val=5; wrap_pulse with count=5.
- Down/sat, from count=1: count 0,0; wrap_pulse on the second step.
- Priority: clear, load=1 (load_val=7) and enable all high -> count=0. Then load+enable -> count=7, no step. n_rst pulsed mid-count -> all outputs 0 immediately.
- FLEX_CNT_PRESCALE_EN, prescale_val=2, enable held: count advances every 3rd cycle. count_enable low for 2 cycles -> prescaler holds. Load resets the prescaler phase.

Source files
------------

// File: rtl/flex_counter_pkg.sv
// Shared types and default widths for the up/down flex counter slice.
// No logic; no latency; no backpressure.
package flex_counter_pkg;

   typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} cnt_dir_e;
   typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} cnt_mode_e;

   localparam int DEF_CNT_BITS      = 8;
   localparam int DEF_PRESCALE_BITS = 4;

endpackage

// File: rtl/flex_prescaler.sv
// Enable prescaler: tick on every (prescale_val+1)th enabled cycle.
// Tick is combinational from the phase register; no backpressure, phase holds while enable is low.
module flex_prescaler
   import flex_counter_pkg::*;
#(
   parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     clear,
   input  logic                     enable,
   input  logic [PRESCALE_BITS-1:0] prescale_val,
   output logic                     tick
);

   localparam logic [PRESCALE_BITS-1:0] PRE_ONE = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};

   logic [PRESCALE_BITS-1:0] phase;

   assign tick = enable && (phase == prescale_val);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         phase <= '0;
      end else if (clear) begin
         phase <= '0;
      end else if (enable) begin
         phase <= tick ? '0 : phase + PRE_ONE;
      end
   end

endmodule

// File: rtl/flex_counter_ud.sv
// Up/down flex counter with load, wrap/saturate and registered terminal/wrap status; prescaler under FLEX_CNT_PRESCALE_EN.
// Latency 1 cycle from step to count_out/terminal_flag/wrap_pulse; no backpressure, steps are taken when presented.
module flex_counter_ud
   import flex_counter_pkg::*;
#(
   parameter int NUM_CNT_BITS  = DEF_CNT_BITS,
   parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     clear,
   input  logic                     load,
   input  logic [NUM_CNT_BITS-1:0]  load_val,
   input  logic                     count_enable,
   input  logic                     up_down,
   input  logic                     sat_mode,
   input  logic [NUM_CNT_BITS-1:0]  rollover_val,
   input  logic [PRESCALE_BITS-1:0] prescale_val,
   output logic [NUM_CNT_BITS-1:0]  count_out,
   output logic                     terminal_flag,
   output logic                     wrap_pulse
);

   localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

   logic                    tick;
   logic                    step;
   cnt_dir_e                dir;
   cnt_mode_e               mode;
   logic [NUM_CNT_BITS-1:0] next_cnt;
   logic                    next_wrap;

`ifdef FLEX_CNT_PRESCALE_EN
   // Load restarts the prescale phase as well as the count.
   flex_prescaler #(
      .PRESCALE_BITS (PRESCALE_BITS)
   ) u_prescaler (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear | load),
      .enable       (count_enable),
      .prescale_val (prescale_val),
      .tick         (tick)
   );
`else
   logic unused_prescale_val;
   assign unused_prescale_val = ^prescale_val;
   assign tick = count_enable;
`endif

   assign step = count_enable & tick;
   assign dir  = cnt_dir_e'(up_down);
   assign mode = cnt_mode_e'(sat_mode);

   always_comb begin
      next_cnt  = count_out;
      next_wrap = 1'b0;
      if (clear) begin
         next_cnt = '0;
      end else if (load) begin
         next_cnt = load_val;
      end else if (step) begin
         if (dir == DIR_UP) begin
            // A zero bound pins up-counting at zero regardless of mode.
            if (rollover_val == '0) begin
               next_cnt  = '0;
               next_wrap = 1'b1;
            end else if (count_out >= rollover_val) begin
               next_cnt  = (mode == MODE_SAT) ? rollover_val : CNT_ONE;
               next_wrap = 1'b1;
            end else begin
               next_cnt = count_out + CNT_ONE;
            end
         end else if (mode == MODE_SAT) begin
            if (count_out == '0) begin
               next_wrap = 1'b1;
            end else begin
               next_cnt = count_out - CNT_ONE;
            end
         end else begin
            if (count_out <= CNT_ONE) begin
               next_cnt  = rollover_val;
               next_wrap = 1'b1;
            end else begin
               next_cnt = count_out - CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_out     <= '0;
         terminal_flag <= 1'b0;
         wrap_pulse    <= 1'b0;
      end else begin
         count_out     <= next_cnt;
         terminal_flag <= (next_cnt == rollover_val);
         wrap_pulse    <= next_wrap;
      end
   end

endmodule

// File: tb/tb_flex_counter_ud.sv
// Self-checking bench for flex_counter_ud: directed scenarios then random stimulus against an integer reference model.
// Covers the prescaled build when FLEX_CNT_PRESCALE_EN is defined.
module tb_flex_counter_ud;

   localparam int W  = 8;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          clear, load, count_enable, up_down, sat_mode;
   logic [W-1:0]  load_val, rollover_val;
   logic [PW-1:0] prescale_val;
   logic [W-1:0]  count_out;
   logic          terminal_flag, wrap_pulse;

   int total  = 0;
   int passed = 0;

   // Reference model state
   int m_cnt   = 0;
   int m_pre   = 0;
   bit m_term  = 0;
   bit m_pulse = 0;

   flex_counter_ud #(.NUM_CNT_BITS(W), .PRESCALE_BITS(PW)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear),
      .load          (load),
      .load_val      (load_val),
      .count_enable  (count_enable),
      .up_down       (up_down),
      .sat_mode      (sat_mode),
      .rollover_val  (rollover_val),
      .prescale_val  (prescale_val),
      .count_out     (count_out),
      .terminal_flag (terminal_flag),
      .wrap_pulse    (wrap_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Next-state of the counter derived directly from the behavioural rules.
   function automatic void model_edge();
      int  rv;
      int  c;
      bit  stp;
      rv = int'(rollover_val);
      c  = m_cnt;
`ifdef FLEX_CNT_PRESCALE_EN
      stp = count_enable && (m_pre == int'(prescale_val));
      if (clear || load)     m_pre = 0;
      else if (count_enable) m_pre = stp ? 0 : (m_pre + 1) % (1 << PW);
`else
      stp = count_enable;
`endif
      m_pulse = 0;
      if (clear)     m_cnt = 0;
      else if (load) m_cnt = int'(load_val);
      else if (stp) begin
         if (up_down) begin
            if (rv == 0)      begin m_cnt = 0; m_pulse = 1; end
            else if (c >= rv) begin m_cnt = sat_mode ? rv : 1; m_pulse = 1; end
            else              m_cnt = c + 1;
         end else if (sat_mode) begin
            if (c == 0) begin m_cnt = 0; m_pulse = 1; end
            else        m_cnt = c - 1;
         end else begin
            if (c <= 1) begin m_cnt = rv; m_pulse = 1; end
            else        m_cnt = c - 1;
         end
      end
      m_term = (m_cnt == rv);
   endfunction

   function automatic void model_reset();
      m_cnt = 0; m_pre = 0; m_term = 0; m_pulse = 0;
   endfunction

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check({tag, ".count"}, 32'(count_out), 32'(m_cnt));
      check({tag, ".term"},  32'(terminal_flag), 32'(m_term));
      check({tag, ".wrap"},  32'(wrap_pulse), 32'(m_pulse));
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".count"}, 32'(count_out), 32'd0);
      check({tag, ".term"},  32'(terminal_flag), 32'd0);
      check({tag, ".wrap"},  32'(wrap_pulse), 32'd0);
   endtask

   initial begin
      n_rst = 1'b0; clear = 0; load = 0; count_enable = 0;
      up_down = 1; sat_mode = 0; load_val = '0; rollover_val = 8'd5; prescale_val = '0;
      #3;
      check_zero("reset");
      model_reset();
      @(posedge clk); #1;
      n_rst = 1'b1;

      // Up / wrap, bound 5
      count_enable = 1;
      for (int i = 0; i < 8; i++) begin
         cycle("up_wrap");
         if (i == 4) check("up_wrap.at_bound_term", 32'(terminal_flag), 32'd1);
         if (i == 5) check("up_wrap.wrap_to_1", 32'(count_out), 32'd1);
      end

      // Up / saturate, bound 3
      count_enable = 0; clear = 1; cycle("clr");
      clear = 0; count_enable = 1; sat_mode = 1; rollover_val = 8'd3;
      for (int i = 0; i < 5; i++) cycle("up_sat");
      check("up_sat.held", 32'(count_out), 32'd3);
      check("up_sat.pulse_on_hold", 32'(wrap_pulse), 32'd1);

      // Down / wrap, load 2 with enable high: load wins
      sat_mode = 0; rollover_val = 8'd5; up_down = 0; load = 1; load_val = 8'd2;
      cycle("load2");
      check("load2.no_step", 32'(count_out), 32'd2);
      load = 0;
      for (int i = 0; i < 3; i++) cycle("down_wrap");
      check("down_wrap.end", 32'(count_out), 32'd4);

      // Down / saturate from 1
      load = 1; load_val = 8'd1; cycle("load1");
      load = 0; sat_mode = 1;
      cycle("down_sat0");
      check("down_sat.first_no_pulse", 32'(wrap_pulse), 32'd0);
      cycle("down_sat1");
      check("down_sat.hold_pulse", 32'(wrap_pulse), 32'd1);

      // Priority: clear over load over step
      clear = 1; load = 1; load_val = 8'd7; up_down = 1; sat_mode = 0;
      cycle("prio_clear");
      check("prio_clear.zero", 32'(count_out), 32'd0);
      clear = 0;
      cycle("prio_load");
      check("prio_load.seven", 32'(count_out), 32'd7);
      load = 0;
      cycle("above_bound");
      for (int i = 0; i < 2; i++) cycle("count_on");

      // Count enable low: level terminal holds
      count_enable = 0;
      for (int i = 0; i < 2; i++) cycle("idle");

      // Zero bound up-counting
      count_enable = 1; rollover_val = 8'd0;
      for (int i = 0; i < 3; i++) cycle("rv0_up");
      up_down = 0;
      for (int i = 0; i < 2; i++) cycle("rv0_down");

      // Asynchronous reset mid-count
      up_down = 1; rollover_val = 8'd9;
      for (int i = 0; i < 3; i++) cycle("pre_rst");
      #2 n_rst = 1'b0;
      #1 check_zero("async_rst");
      model_reset();
      @(posedge clk); #1;
      check_zero("rst_held");
      n_rst = 1'b1;

`ifdef FLEX_CNT_PRESCALE_EN
      prescale_val = 4'd2; rollover_val = 8'd50;
      for (int i = 0; i < 7; i++) cycle("pre_run");
      count_enable = 0;
      for (int i = 0; i < 2; i++) cycle("pre_pause");
      count_enable = 1;
      for (int i = 0; i < 2; i++) cycle("pre_resume");
      load = 1; load_val = 8'd10; cycle("pre_load");
      load = 0;
      for (int i = 0; i < 4; i++) cycle("pre_after_load");
`endif

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         clear        = ($urandom_range(0, 31) == 0);
         load         = ($urandom_range(0, 15) == 0);
         load_val     = W'($urandom_range(0, 20));
         count_enable = ($urandom_range(0, 9) < 7);
         up_down      = 1'($urandom);
         sat_mode     = 1'($urandom);
         if ($urandom_range(0, 7) == 0) rollover_val = W'($urandom);
         else if ($urandom_range(0, 3) == 0) rollover_val = W'($urandom_range(0, 12));
         prescale_val = PW'($urandom_range(0, 3));
         cycle("rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
